// File: rtl/wb_sweep_master_pkg.sv
// Shared bus package for the sweep master: FSM encoding, timeout default,
// Wishbone select constant and the bus address map pages.
package wb_sweep_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DWELL    = 2'd3
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  localparam logic [3:0]  WB_SEL_ALL        = 4'hF;
  localparam logic [29:0] ADDR_CONTROL_PAGE = 30'h0000_2040;
  localparam logic [29:0] ADDR_FM_PAGE      = 30'h0000_2080;
  localparam logic [29:0] ADDR_LO_PAGE      = 30'h0000_20C0;

  // Sweep values wrap modulo 2^32.
  function automatic logic [31:0] next_value(input logic [31:0] value,
                                             input logic [31:0] step);
    return value + step;
  endfunction

endpackage

// File: rtl/wb_sweep_master.sv
// Pipelined Wishbone master that writes an arithmetic sweep of values to one
// register, with per-write dwell, abort, bus-error and ack-timeout handling.
module wb_sweep_master
  import wb_sweep_master_pkg::*;
#(
  parameter int DWELL_BITS = 24,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [29:0]           i_base_addr,
  input  logic [31:0]           i_start_value,
  input  logic [31:0]           i_step,
  input  logic [15:0]           i_count,
  input  logic [DWELL_BITS-1:0] i_dwell,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [29:0]           o_wb_addr,
  output logic [31:0]           o_wb_data,
  output logic [3:0]            o_wb_sel,
  input  logic                  i_wb_stall,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_err,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e                  state_q;
  logic                    cyc_q, stb_q, we_q, busy_q, done_q, err_q, abort_q;
  logic [29:0]             addr_q;
  logic [31:0]             data_q, step_q;
  logic [15:0]             remaining_q;
  logic [DWELL_BITS-1:0]   dwell_q, dwell_cnt_q;
  logic [TW-1:0]           timer_q;
  logic [31:0]             data_d;

  assign data_d = next_value(data_q, step_q);

  // NOTE: all state, outputs and datapath use non-blocking assignments in this
  // one clocked block so every output is a flop and reads see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      step_q      <= '0;
      remaining_q <= '0;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      timer_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            addr_q      <= i_base_addr;
            data_q      <= i_start_value;
            step_q      <= i_step;
            dwell_q     <= i_dwell;
            remaining_q <= i_count;
            abort_q     <= 1'b0;
            if (i_count == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ST_REQ;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (i_abort) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (!i_wb_stall) begin
            state_q <= ST_WAIT_ACK;
            stb_q   <= 1'b0;
            timer_q <= '0;
          end
        end
        ST_WAIT_ACK: begin
          if (i_abort) abort_q <= 1'b1;
          // Error beats a same-cycle ack; abort only decides what follows an ack.
          if (i_wb_err || (!i_wb_ack && timer_q == TMO_LAST)) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else if (i_wb_ack) begin
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            data_q      <= data_d;
            remaining_q <= remaining_q - 16'd1;
            if (remaining_q == 16'd1 || abort_q || i_abort) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ST_DWELL;
              dwell_cnt_q <= dwell_q;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_DWELL: begin
          if (i_abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (dwell_cnt_q < DWELL_BITS'(2)) begin
            // The ack-exit cycle counts as the first idle cycle; dwell 0 acts as 1.
            state_q <= ST_REQ;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
          end else begin
            dwell_cnt_q <= dwell_cnt_q - DWELL_BITS'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = data_q;
  assign o_wb_sel  = WB_SEL_ALL;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule

// File: doc/wb_sweep_master.md
WB_SWEEP_MASTER -- requirements
Module: wb_sweep_master

Interface
REQ-001 Parameter DWELL_BITS, default 24, width of dwell counter.
REQ-002 Parameter TIMEOUT, default 255, max cycles waiting for ack/err after strobe accepted.
REQ-003 i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 i_reset  in  1  reset, synchronous, active-high.
REQ-005 i_start  in  1  one-cycle pulse; begin sweep (ignored while o_busy).
REQ-006 i_abort  in  1  request early termination of sweep.
REQ-007 i_base_addr  in  30  word address of target register.
REQ-008 i_start_value  in  32  first data word written.
REQ-009 i_step  in  32  increment added after each accepted write.
REQ-010 i_count  in  16  number of writes in sweep.
REQ-011 i_dwell  in  DWELL_BITS  idle cycles between writes.
REQ-012 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  pipelined Wishbone master controls.
REQ-013 o_wb_addr  out  30; o_wb_data  out  32; o_wb_sel  out  4  (always 4'hF).
REQ-014 i_wb_stall, i_wb_ack, i_wb_err  in  1 each  slave responses.
REQ-015 o_busy  out  1  high from cycle after accepted start until return to IDLE.
REQ-016 o_done  out  1  one-cycle pulse on normal or aborted completion.
REQ-017 o_err  out  1  one-cycle pulse on bus error or timeout.

Function
REQ-018 States: IDLE, REQ, WAIT_ACK, DWELL; all outputs registered.
REQ-019 IDLE + i_start: latch all i_* parameters; count==0 -> o_done pulse next cycle, no bus activity, stay IDLE; else -> REQ with cyc=stb=we=1 in next cycle.
REQ-020 REQ: hold cyc, stb, addr, data stable while i_wb_stall=1; on stall=0 edge -> WAIT_ACK, stb=0, cyc=1.
REQ-021 WAIT_ACK: i_wb_ack/i_wb_err sampled only here; ack and err same cycle -> err wins.
REQ-022 On ack: cyc=0 next cycle; value <= value+step modulo 2^32; remaining decrements; remaining reaches 0 -> o_done, IDLE; else DWELL.
REQ-023 DWELL: i_dwell idle cycles (cyc=0) then REQ; dwell 0 -> REQ on cycle immediately after ack-exit cycle.
REQ-024 On err, or TIMEOUT cycles in WAIT_ACK without ack/err: cyc=0, o_err pulse, IDLE; no o_done.
REQ-025 i_abort in REQ or DWELL: cyc=stb=0 next cycle, o_done pulse, IDLE; in WAIT_ACK abort is latched and honoured after ack/err/timeout, suppressing further writes.
REQ-026 i_start while busy ignored; i_start and i_abort together in IDLE -> start wins, abort ignored.
REQ-027 o_wb_addr = latched base address throughout; inputs changing mid-sweep have no effect.
REQ-028 Single outstanding transaction at all times; stb never asserted without cyc.

Reset
REQ-029 i_reset forces IDLE; cyc=stb=we=0, o_busy=o_done=o_err=0, counters 0, addr/data 0, sel 4'hF.
REQ-030 Reset mid-transaction drops cyc in next cycle with no o_done/o_err pulse.

Structure
REQ-031 State encoding, TIMEOUT default and bus address map constants (control 0x2040, fm 0x2080, lo 0x20C0 pages) live in the shared bus package.
REQ-032 Single module; no sub-modules; no inferred memory.

Verification
REQ-033 base=0x2080, start=0x1000, step=0x10, count=3, dwell=2, ack 1 cycle after strobe -> data 0x1000, 0x1010, 0x1020, cyc low exactly 2 cycles between, o_done once.
REQ-034 count=3 with stall held 5 cycles on write 2 -> stb held 5 extra cycles, data stable 0x1010, sequence otherwise unchanged.
REQ-035 start=0xFFFFFFF8, step=0x10, count=2 -> data 0xFFFFFFF8 then 0x00000008.
REQ-036 err on write 2 of 4 -> o_err pulse, cyc low next cycle, no o_done, 2 strobes total.
REQ-037 no ack ever, TIMEOUT=255 -> cyc drops 255 cycles after strobe accepted, o_err pulse.
REQ-038 abort during DWELL after write 1 of 5, and count=0 start -> o_done pulse, no further strobes.
